cpu_req_axi_master: RTL and testbench
=====================================

CPU_REQ_AXI_MASTER -- requirements
Module: cpu_req_axi_master

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH, default 32, address width; and DATA_WIDTH, default 32, data width (32 or 64).
REQ-002 ACLK  in  1  clock; all logic on rising edge.
REQ-003 ARESETN  in  1  reset, synchronous, active-low.
REQ-004 read_req  in  1  CPU read request, held high until read_done.
REQ-005 read_addr  in  ADDR_WIDTH  read address, stable while read_req is high.
REQ-006 read_ready  out  1  one-cycle pulse on the AR handshake.
REQ-007 read_valid  out  1  one-cycle pulse on the R handshake.
REQ-008 read_data  out  DATA_WIDTH  captured RDATA, held until the next R handshake.
REQ-009 read_done  out  1  one-cycle pulse, read transaction complete.
REQ-010 write_req  in  1  CPU write request, held high until write_done.
REQ-011 write_addr, write_data  in  ADDR_WIDTH, DATA_WIDTH  write address and data, stable while write_req is high.
REQ-012 write_ready, write_data_ready  out  1 each  one-cycle pulses on the AW and W handshakes respectively.
REQ-013 write_done  out  1  one-cycle pulse, B response received.
REQ-014 M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID  out  ADDR_WIDTH, 3, 1  write address channel; M_AXI_AWREADY  in  1.
REQ-015 M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID  out  DATA_WIDTH, DATA_WIDTH/8, 1  write data channel; M_AXI_WREADY  in  1.
REQ-016 M_AXI_BRESP, M_AXI_BVALID  in  2, 1  write response; M_AXI_BREADY  out  1.
REQ-017 M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID  out  ADDR_WIDTH, 3, 1  read address channel; M_AXI_ARREADY  in  1.
REQ-018 M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID  in  DATA_WIDTH, 2, 1  read data channel; M_AXI_RREADY  out  1.

Function
REQ-019 Read FSM SHALL have the states RD_IDLE, RD_ADDR, RD_DATA, and RD_DONE, and the write FSM SHALL run independently of it.
REQ-020 In RD_IDLE with read_req=1, the block SHALL register read_addr into ARADDR, set ARVALID=1 next cycle, and go to RD_ADDR.
REQ-021 In RD_ADDR, ARVALID SHALL stay high with ARADDR stable until ARREADY=1; on that cycle read_ready pulses, ARVALID drops, and the FSM goes to RD_DATA.
REQ-022 In RD_DATA, RREADY SHALL be 1; on RVALID=1, read_data<=RDATA, read_valid pulses, and the FSM goes to RD_DONE.
REQ-023 RD_DONE SHALL assert read_done for exactly one cycle and return to RD_IDLE; a new read_req is not sampled in RD_DONE, so at least one bubble cycle separates reads.
REQ-024 Write FSM states SHALL be WR_IDLE, WR_XFER, WR_RESP, and WR_DONE.
REQ-025 In WR_IDLE with write_req=1, AWADDR/WDATA SHALL register from the request, WSTRB is all ones, AWVALID=WVALID=1 from the next cycle, and the FSM goes to WR_XFER.
REQ-026 In WR_XFER, AW and W SHALL complete independently in any order or in the same cycle; each VALID drops after its own handshake, and the FSM leaves for WR_RESP only once both have completed.
REQ-027 In WR_RESP, BREADY SHALL be 1; on BVALID the FSM goes to WR_DONE, which pulses write_done for one cycle and returns to WR_IDLE.
REQ-028 Simultaneous read_req and write_req SHALL both start in the same cycle, with no ordering between channels.
REQ-029 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-030 No VALID SHALL deassert before its READY, and no address or data SHALL change while its VALID is high.
REQ-031 Latency SHALL be: ARVALID 1 cycle after read_req; read_done 1 cycle after the R handshake.

Reset
REQ-032 When ARESETN=0 at an edge, both FSMs SHALL go to IDLE and all outputs SHALL be 0 (read_data=0, all VALID/READY/pulse outputs=0).
REQ-033 Reset mid-transaction SHALL abort with no completion pulse, and no VALID SHALL be driven during reset.

Configuration
REQ-034 With CPU_REQ_AXI_ERR_EN defined, the block SHALL add outputs err (1, sticky) and err_addr (ADDR_WIDTH); RRESP or BRESP not equal to 2'b00 sets err and captures the transaction address on the first error only; err clears only on reset.
REQ-035 Without CPU_REQ_AXI_ERR_EN, those ports SHALL be absent and RRESP/BRESP are ignored.

Structure
REQ-036 A shared package SHALL hold the FSM state encodings (2-bit), the AXI response constants OKAY=2'b00 and SLVERR=2'b10, and PROT_DEFAULT=3'b000.
REQ-037 The design SHALL be one flat module with no sub-modules; the two FSMs are separate always blocks.

Verification
REQ-038 read_req addr=0x80000004, ARREADY=1 immediately, RVALID two cycles later with 0xDEADBEEF -> ARADDR=0x80000004, read_data=0xDEADBEEF, and read_done 1 cycle after the R handshake.
REQ-039 write_req addr=0x80000010 data=0x12345678, WREADY 3 cycles before AWREADY, BVALID 1 cycle later -> each VALID drops after its own handshake, BREADY=1, write_done pulses once.
REQ-040 ARREADY held low 10 cycles -> ARVALID=1 and ARADDR stable throughout, and read_ready pulses only when ARREADY rises.
REQ-041 read_req and write_req asserted in the same cycle -> both transactions complete, with read_done and write_done each pulsing once.
REQ-042 ARESETN low while in WR_RESP -> all outputs 0 the next cycle, no write_done pulse, and a fresh write then completes normally.
REQ-043 With CPU_REQ_AXI_ERR_EN, BRESP=SLVERR on addr 0x80000020 followed by an RRESP error -> err=1, err_addr=0x80000020 unchanged.

Source files
------------

// File: rtl/cpu_req_axi_master_pkg.sv
// cpu_req_axi_master_pkg
// Shared definitions for cpu_req_axi_master: 2-bit state encodings for the
// independent read and write FSMs, AXI response codes and the fixed PROT value.
// No ports (package).

package cpu_req_axi_master_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_DONE = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_XFER = 2'd1,
    WR_RESP = 2'd2,
    WR_DONE = 2'd3
  } wr_state_t;

  localparam logic [1:0] OKAY         = 2'b00;
  localparam logic [1:0] SLVERR       = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Any response other than OKAY counts as an error (SLVERR, DECERR, EXOKAY
  // is never expected from a single-beat non-exclusive access).
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/cpu_req_axi_master.sv
// cpu_req_axi_master
// Turns simple CPU read/write request strobes into single-beat AXI4-Lite
// transactions. Read and write paths are independent FSMs and may run at
// the same time.
//
// Ports:
//   ACLK, ARESETN            clock, synchronous active-low reset
//   read_req/read_addr       CPU read request (held until read_done)
//   read_ready/read_valid    pulses on the AR and R handshakes
//   read_data/read_done      captured RDATA (held), completion pulse
//   write_req/addr/data      CPU write request (held until write_done)
//   write_ready              pulse on the AW handshake
//   write_data_ready         pulse on the W handshake
//   write_done               pulse when the B response is accepted
//   M_AXI_AW*/W*/B*          AXI write address/data/response channels
//   M_AXI_AR*/R*             AXI read address/data channels
//   err, err_addr            only with CPU_REQ_AXI_ERR_EN defined: sticky
//                            error flag and address of the first failing
//                            transaction
//
// Build option: define CPU_REQ_AXI_ERR_EN to add the error-capture ports.

module cpu_req_axi_master
  import cpu_req_axi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    read_req,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic                    read_ready,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_done,
  input  logic                    write_req,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic                    write_ready,
  output logic                    write_data_ready,
  output logic                    write_done,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
`ifdef CPU_REQ_AXI_ERR_EN
  ,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   err_addr
`endif
);

  rd_state_t rd_state, rd_state_nxt;
  wr_state_t wr_state, wr_state_nxt;

  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done;
  logic                    w_done;

  logic ar_pending, ar_hs, r_open, r_hs;
  logic aw_pending, aw_hs, w_pending, w_hs, b_open, b_hs;

  // Every VALID, READY and pulse is qualified with ARESETN so nothing is
  // driven while reset is held, even before the state registers clear.
  assign ar_pending = ARESETN && (rd_state == RD_ADDR);
  assign ar_hs      = ar_pending && M_AXI_ARREADY;
  assign r_open     = ARESETN && (rd_state == RD_DATA);
  assign r_hs       = r_open && M_AXI_RVALID;

  assign aw_pending = ARESETN && (wr_state == WR_XFER) && !aw_done;
  assign aw_hs      = aw_pending && M_AXI_AWREADY;
  assign w_pending  = ARESETN && (wr_state == WR_XFER) && !w_done;
  assign w_hs       = w_pending && M_AXI_WREADY;
  assign b_open     = ARESETN && (wr_state == WR_RESP);
  assign b_hs       = b_open && M_AXI_BVALID;

  // Read path registers: state, the address latched at request time (so
  // ARADDR cannot move while ARVALID is high) and the returned data.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state <= RD_IDLE;
      araddr_q <= '0;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if ((rd_state == RD_IDLE) && read_req)
        araddr_q <= read_addr;
      if (r_hs)
        rdata_q <= M_AXI_RDATA;
    end
  end

  // Read next-state. RD_DONE always returns to idle without looking at
  // read_req, which forces a bubble between back-to-back reads.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (read_req)      rd_state_nxt = RD_ADDR;
      RD_ADDR: if (M_AXI_ARREADY) rd_state_nxt = RD_DATA;
      RD_DATA: if (M_AXI_RVALID)  rd_state_nxt = RD_DONE;
      RD_DONE:                    rd_state_nxt = RD_IDLE;
      default:                    rd_state_nxt = RD_IDLE;
    endcase
  end

  // Write path registers. aw_done/w_done remember which of the two
  // channels has already completed so the other may finish later.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      if ((wr_state == WR_IDLE) && write_req) begin
        awaddr_q <= write_addr;
        wdata_q  <= write_data;
        wstrb_q  <= '1;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  // Write next-state: leave WR_XFER only once both AW and W are done,
  // counting a handshake that happens in the current cycle.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      WR_IDLE: if (write_req) wr_state_nxt = WR_XFER;
      WR_XFER: if ((aw_done || aw_hs) && (w_done || w_hs))
                 wr_state_nxt = WR_RESP;
      WR_RESP: if (M_AXI_BVALID) wr_state_nxt = WR_DONE;
      WR_DONE:                   wr_state_nxt = WR_IDLE;
      default:                   wr_state_nxt = WR_IDLE;
    endcase
  end

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = ar_pending;
  assign M_AXI_RREADY  = r_open;
  assign read_ready    = ar_hs;
  assign read_valid    = r_hs;
  assign read_data     = rdata_q;
  assign read_done     = ARESETN && (rd_state == RD_DONE);

  assign M_AXI_AWADDR     = awaddr_q;
  assign M_AXI_AWPROT     = PROT_DEFAULT;
  assign M_AXI_AWVALID    = aw_pending;
  assign M_AXI_WDATA      = wdata_q;
  assign M_AXI_WSTRB      = wstrb_q;
  assign M_AXI_WVALID     = w_pending;
  assign M_AXI_BREADY     = b_open;
  assign write_ready      = aw_hs;
  assign write_data_ready = w_hs;
  assign write_done       = ARESETN && (wr_state == WR_DONE);

`ifdef CPU_REQ_AXI_ERR_EN
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;

  // Sticky error capture: only the first failing response records its
  // address. A write error wins if both fail in the same cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (!err_q) begin
      if (b_hs && resp_is_err(M_AXI_BRESP)) begin
        err_q      <= 1'b1;
        err_addr_q <= awaddr_q;
      end else if (r_hs && resp_is_err(M_AXI_RRESP)) begin
        err_q      <= 1'b1;
        err_addr_q <= araddr_q;
      end
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_resp;
  assign unused_resp = ^{M_AXI_RRESP, M_AXI_BRESP};
`endif

endmodule

// File: tb/tb_cpu_req_axi_master.sv
// tb_cpu_req_axi_master
// Directed bench for cpu_req_axi_master acting as the AXI slave and CPU.
// Expected {address, data} pairs are queued when a request is issued and
// popped when the DUT completes the transaction.

module tb_cpu_req_axi_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          read_req = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic          read_ready, read_valid, read_done;
  logic [DW-1:0] read_data;
  logic          write_req = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_ready, write_data_ready, write_done;
  logic [AW-1:0] M_AXI_AWADDR;
  logic [2:0]    M_AXI_AWPROT;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY = 1'b0;
  logic [DW-1:0] M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY = 1'b0;
  logic [1:0]    M_AXI_BRESP = 2'b00;
  logic          M_AXI_BVALID = 1'b0;
  logic          M_AXI_BREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic [2:0]    M_AXI_ARPROT;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY = 1'b0;
  logic [DW-1:0] M_AXI_RDATA = '0;
  logic [1:0]    M_AXI_RRESP = 2'b00;
  logic          M_AXI_RVALID = 1'b0;
  logic          M_AXI_RREADY;
`ifdef CPU_REQ_AXI_ERR_EN
  logic          err;
  logic [AW-1:0] err_addr;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [63:0] rd_q[$];
  logic [63:0] wr_q[$];
  logic [1:0]  rresp_drv = 2'b00;
  logic [1:0]  bresp_drv = 2'b00;

  always #5 ACLK = ~ACLK;

  cpu_req_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .read_req(read_req), .read_addr(read_addr), .read_ready(read_ready),
    .read_valid(read_valid), .read_data(read_data), .read_done(read_done),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_ready(write_ready), .write_data_ready(write_data_ready),
    .write_done(write_done),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
`ifdef CPU_REQ_AXI_ERR_EN
    , .err(err), .err_addr(err_addr)
`endif
  );

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cycle();
    @(posedge ACLK);
    #2;
  endtask

  // Let combinational outputs follow the newly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [AW-1:0] ra,
                               input logic wq, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
    read_req   = rq;
    read_addr  = ra;
    write_req  = wq;
    write_addr = wa;
    write_data = wd;
  endtask

  // One read: AR accepted after ar_wait cycles, R returned after r_wait
  // more. With hold set, read_req stays high through RD_DONE to show the
  // request is not resampled there.
  task automatic readTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int ar_wait, input int r_wait, input bit hold);
    logic [63:0]   exp;
    logic [AW-1:0] cap_addr;
    applyStimulus(1'b1, addr, write_req, write_addr, write_data);
    rd_q.push_back({addr, data});
    cycle();
    for (int i = 0; i < ar_wait; i++) begin
      settle();
      checkBit("arvalid_wait", M_AXI_ARVALID, 1'b1);
      checkOutput("araddr_stable", M_AXI_ARADDR, addr);
      checkBit("read_ready_early", read_ready, 1'b0);
      cycle();
    end
    M_AXI_ARREADY = 1'b1;
    settle();
    checkBit("arvalid_hs", M_AXI_ARVALID, 1'b1);
    checkBit("read_ready_hs", read_ready, 1'b1);
    cap_addr = M_AXI_ARADDR;
    cycle();
    M_AXI_ARREADY = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      settle();
      checkBit("rready_wait", M_AXI_RREADY, 1'b1);
      checkBit("arvalid_dropped", M_AXI_ARVALID, 1'b0);
      checkBit("read_valid_early", read_valid, 1'b0);
      cycle();
    end
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = data;
    M_AXI_RRESP  = rresp_drv;
    settle();
    checkBit("rready_hs", M_AXI_RREADY, 1'b1);
    checkBit("read_valid_hs", read_valid, 1'b1);
    cycle();
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA  = '0;
    M_AXI_RRESP  = 2'b00;
    if (!hold) read_req = 1'b0;
    settle();
    checkBit("read_done", read_done, 1'b1);
    exp = rd_q.pop_front();
    checkOutput("read_addr_sb", cap_addr, exp[63:32]);
    checkOutput("read_data_sb", read_data, exp[31:0]);
    cycle();
    settle();
    checkBit("read_done_single", read_done, 1'b0);
    checkBit("arvalid_bubble", M_AXI_ARVALID, 1'b0);
    checkOutput("read_data_held", read_data, exp[31:0]);
  endtask

  // One write: AW accepted in XFER cycle aw_wait, W in cycle w_wait,
  // then BVALID after b_wait cycles of WR_RESP.
  task automatic writeTxn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int aw_wait, input int w_wait, input int b_wait);
    logic [63:0]   exp;
    logic [AW-1:0] cap_aw;
    logic [DW-1:0] cap_w;
    int last;
    applyStimulus(read_req, read_addr, 1'b1, addr, data);
    wr_q.push_back({addr, data});
    last = (aw_wait > w_wait) ? aw_wait : w_wait;
    cap_aw = '0;
    cap_w  = '0;
    cycle();
    for (int k = 0; k <= last; k++) begin
      M_AXI_AWREADY = (k == aw_wait);
      M_AXI_WREADY  = (k == w_wait);
      settle();
      checkBit("awvalid", M_AXI_AWVALID, k <= aw_wait);
      checkBit("wvalid", M_AXI_WVALID, k <= w_wait);
      checkBit("write_ready", write_ready, k == aw_wait);
      checkBit("write_data_ready", write_data_ready, k == w_wait);
      checkBit("bready_xfer", M_AXI_BREADY, 1'b0);
      if (k <= aw_wait) checkOutput("awaddr_stable", M_AXI_AWADDR, addr);
      if (k <= w_wait)  checkOutput("wstrb", {28'h0, M_AXI_WSTRB}, 32'hF);
      if (k == aw_wait) cap_aw = M_AXI_AWADDR;
      if (k == w_wait)  cap_w  = M_AXI_WDATA;
      cycle();
    end
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    for (int i = 0; i < b_wait; i++) begin
      settle();
      checkBit("bready_wait", M_AXI_BREADY, 1'b1);
      checkBit("write_done_early", write_done, 1'b0);
      cycle();
    end
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = bresp_drv;
    settle();
    checkBit("bready_hs", M_AXI_BREADY, 1'b1);
    cycle();
    M_AXI_BVALID = 1'b0;
    M_AXI_BRESP  = 2'b00;
    write_req    = 1'b0;
    settle();
    checkBit("write_done", write_done, 1'b1);
    exp = wr_q.pop_front();
    checkOutput("write_addr_sb", cap_aw, exp[63:32]);
    checkOutput("write_data_sb", cap_w, exp[31:0]);
    cycle();
    settle();
    checkBit("write_done_single", write_done, 1'b0);
  endtask

  initial begin
    logic [63:0] exp_r;
    logic [63:0] exp_w;

    $display("[TB] reset state");
    cycle();
    cycle();
    settle();
    checkBit("rst_arvalid", M_AXI_ARVALID, 1'b0);
    checkBit("rst_awvalid", M_AXI_AWVALID, 1'b0);
    checkBit("rst_wvalid", M_AXI_WVALID, 1'b0);
    checkBit("rst_rready", M_AXI_RREADY, 1'b0);
    checkBit("rst_bready", M_AXI_BREADY, 1'b0);
    checkBit("rst_read_done", read_done, 1'b0);
    checkBit("rst_write_done", write_done, 1'b0);
    checkOutput("rst_read_data", read_data, 32'h0);
    checkOutput("rst_araddr", M_AXI_ARADDR, 32'h0);
    checkOutput("rst_prot", {26'h0, M_AXI_ARPROT, M_AXI_AWPROT}, 32'h0);
`ifdef CPU_REQ_AXI_ERR_EN
    checkBit("rst_err", err, 1'b0);
`endif
    ARESETN = 1'b1;
    cycle();

    $display("[TB] single read");
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    settle();
    checkBit("idle_arvalid", M_AXI_ARVALID, 1'b0);
    readTxn(32'h8000_0004, 32'hDEAD_BEEF, 0, 1, 1'b0);

    $display("[TB] write, W before AW");
    writeTxn(32'h8000_0010, 32'h1234_5678, 3, 0, 0);

    $display("[TB] AR stalled ten cycles");
    readTxn(32'hA000_0100, 32'h0BAD_F00D, 10, 0, 1'b0);

    $display("[TB] back-to-back reads with request held");
    readTxn(32'h1111_0000, 32'hCAFE_F00D, 0, 0, 1'b1);
    readTxn(32'h2222_0000, 32'h55AA_55AA, 2, 3, 1'b0);

    $display("[TB] write orderings");
    writeTxn(32'h8000_0040, 32'hA5A5_A5A5, 0, 0, 2);
    writeTxn(32'h8000_0044, 32'h0F0F_0F0F, 2, 2, 1);
    writeTxn(32'h8000_0048, 32'hFEED_FACE, 1, 4, 0);

    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 32'h9000_0000, 1'b1, 32'h9000_0100, 32'h3333_4444);
    rd_q.push_back({32'h9000_0000, 32'h7777_8888});
    wr_q.push_back({32'h9000_0100, 32'h3333_4444});
    M_AXI_ARREADY = 1'b1;
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    cycle();
    settle();
    exp_w = wr_q.pop_front();
    checkBit("sim_arvalid", M_AXI_ARVALID, 1'b1);
    checkBit("sim_awvalid", M_AXI_AWVALID, 1'b1);
    checkBit("sim_wvalid", M_AXI_WVALID, 1'b1);
    checkOutput("sim_awaddr", M_AXI_AWADDR, exp_w[63:32]);
    checkOutput("sim_wdata", M_AXI_WDATA, exp_w[31:0]);
    checkOutput("sim_araddr", M_AXI_ARADDR, 32'h9000_0000);
    cycle();
    M_AXI_ARREADY = 1'b0;
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    M_AXI_RVALID  = 1'b1;
    M_AXI_RDATA   = 32'h7777_8888;
    M_AXI_BVALID  = 1'b1;
    settle();
    checkBit("sim_rready", M_AXI_RREADY, 1'b1);
    checkBit("sim_bready", M_AXI_BREADY, 1'b1);
    cycle();
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA  = '0;
    M_AXI_BVALID = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    settle();
    exp_r = rd_q.pop_front();
    checkBit("sim_read_done", read_done, 1'b1);
    checkBit("sim_write_done", write_done, 1'b1);
    checkOutput("sim_read_data", read_data, exp_r[31:0]);
    cycle();
    settle();
    checkBit("sim_read_done_single", read_done, 1'b0);
    checkBit("sim_write_done_single", write_done, 1'b0);

    $display("[TB] reset during WR_RESP");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h8000_0030, 32'h0000_0077);
    M_AXI_AWREADY = 1'b1;
    M_AXI_WREADY  = 1'b1;
    cycle();
    settle();
    checkBit("abort_awvalid", M_AXI_AWVALID, 1'b1);
    cycle();
    M_AXI_AWREADY = 1'b0;
    M_AXI_WREADY  = 1'b0;
    settle();
    checkBit("abort_bready", M_AXI_BREADY, 1'b1);
    ARESETN = 1'b0;
    settle();
    checkBit("inrst_bready", M_AXI_BREADY, 1'b0);
    checkBit("inrst_awvalid", M_AXI_AWVALID, 1'b0);
    cycle();
    ARESETN      = 1'b1;
    write_req    = 1'b0;
    M_AXI_BVALID = 1'b1;
    settle();
    checkBit("postrst_bready", M_AXI_BREADY, 1'b0);
    checkBit("postrst_write_done", write_done, 1'b0);
    checkOutput("postrst_read_data", read_data, 32'h0);
    checkOutput("postrst_awaddr", M_AXI_AWADDR, 32'h0);
    cycle();
    M_AXI_BVALID = 1'b0;
    settle();
    checkBit("postrst_write_done2", write_done, 1'b0);
    checkBit("postrst_awvalid", M_AXI_AWVALID, 1'b0);
    writeTxn(32'h8000_0050, 32'h600D_600D, 1, 0, 1);

`ifdef CPU_REQ_AXI_ERR_EN
    $display("[TB] error capture");
    bresp_drv = 2'b10;
    writeTxn(32'h8000_0020, 32'h0000_0001, 0, 0, 0);
    bresp_drv = 2'b00;
    checkBit("err_set", err, 1'b1);
    checkOutput("err_addr_first", err_addr, 32'h8000_0020);
    rresp_drv = 2'b10;
    readTxn(32'h8000_0060, 32'h0000_0002, 0, 0, 1'b0);
    rresp_drv = 2'b00;
    checkBit("err_sticky", err, 1'b1);
    checkOutput("err_addr_kept", err_addr, 32'h8000_0020);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
